// File: rtl/jt900h_blkmov_if.sv
// rtl/jt900h_blkmov_if.sv - memory bus handshake between the block-move sequencer and the memory interface
interface jt900h_blkmov_if #(
  parameter int AW = 24
);
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_wr;
  logic          mem_wsz;
  logic          mem_ack;
  logic [15:0]   mem_din;
  logic [15:0]   mem_dout;

  modport master (
    output mem_addr, mem_rd, mem_wr, mem_wsz, mem_dout,
    input  mem_ack, mem_din
  );

  modport slave (
    input  mem_addr, mem_rd, mem_wr, mem_wsz, mem_dout,
    output mem_ack, mem_din
  );
endinterface

// File: rtl/jt900h_blkmov_ctl.sv
// rtl/jt900h_blkmov_ctl.sv - LDI/LDIR/LDD/LDDR sequencer; JT900H_BLKMOV_IRQ_EN makes repeats interruptible
module jt900h_blkmov_ctl #(
  parameter int AW = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cen,
  input  logic                  start,
  input  logic                  dec,
  input  logic                  rep,
  input  logic                  wsize,
  input  logic [31:0]           src_ptr,
  input  logic [31:0]           dst_ptr,
  input  logic [15:0]           cnt,
  jt900h_blkmov_if.master       mem,
  output logic                  ptr_upd,
  output logic                  cnt_dec,
  output logic                  busy,
  output logic                  done,
  output logic                  flag_v,
  input  logic                  irq_pend,
  output logic                  suspended
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_UPDATE,
    S_DONE
  } state_t;

  state_t      state, state_nx;
  logic [31:0] src_q, dst_q;
  logic [15:0] cnt_q, data_q;
  logic        dec_q, rep_q, wsz_q, flag_q;
  logic [15:0] cnt_m1;
  logic [31:0] step;
  logic        more;
  logic        irq_stop;

  assign cnt_m1 = cnt_q - 16'd1;
  assign step   = wsz_q ? 32'd2 : 32'd1;
  assign more   = rep_q && (cnt_m1 != 16'd0);

`ifdef JT900H_BLKMOV_IRQ_EN
  logic susp_q;
  // Registers are already consistent at this point, so stopping early is safe.
  assign irq_stop  = more && irq_pend;
  assign suspended = cen && (state == S_DONE) && susp_q;
`else
  logic unused_irq;
  assign unused_irq = irq_pend;
  assign irq_stop   = 1'b0;
  assign suspended  = 1'b0;
`endif

  always_comb begin
    state_nx     = state;
    mem.mem_rd   = 1'b0;
    mem.mem_wr   = 1'b0;
    mem.mem_addr = '0;
    ptr_upd      = 1'b0;
    cnt_dec      = 1'b0;
    done         = 1'b0;
    busy         = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_READ;
      end
      S_READ: begin
        busy         = 1'b1;
        mem.mem_rd   = 1'b1;
        mem.mem_addr = src_q[AW-1:0];
        if (mem.mem_ack) state_nx = S_WRITE;
      end
      S_WRITE: begin
        busy         = 1'b1;
        mem.mem_wr   = 1'b1;
        mem.mem_addr = dst_q[AW-1:0];
        if (mem.mem_ack) state_nx = S_UPDATE;
      end
      S_UPDATE: begin
        busy     = 1'b1;
        ptr_upd  = cen;
        cnt_dec  = cen;
        state_nx = (more && !irq_stop) ? S_READ : S_DONE;
      end
      S_DONE: begin
        done     = cen;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign mem.mem_wsz  = wsz_q;
  assign mem.mem_dout = data_q;
  assign flag_v       = flag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      src_q  <= '0;
      dst_q  <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      dec_q  <= 1'b0;
      rep_q  <= 1'b0;
      wsz_q  <= 1'b0;
      flag_q <= 1'b0;
`ifdef JT900H_BLKMOV_IRQ_EN
      susp_q <= 1'b0;
`endif
    end else if (cen) begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (start) begin
            src_q <= src_ptr;
            dst_q <= dst_ptr;
            cnt_q <= cnt;
            dec_q <= dec;
            rep_q <= rep;
            wsz_q <= wsize;
`ifdef JT900H_BLKMOV_IRQ_EN
            susp_q <= 1'b0;
`endif
          end
        end
        S_READ: begin
          if (mem.mem_ack) data_q <= wsz_q ? mem.mem_din : {8'h00, mem.mem_din[7:0]};
        end
        S_UPDATE: begin
          src_q  <= dec_q ? src_q - step : src_q + step;
          dst_q  <= dec_q ? dst_q - step : dst_q + step;
          cnt_q  <= cnt_m1;
          flag_q <= (cnt_m1 != 16'd0);
`ifdef JT900H_BLKMOV_IRQ_EN
          susp_q <= irq_stop;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jt900h_blkmov_ctl.sv
// tb/tb_jt900h_blkmov_ctl.sv - scoreboard bench for jt900h_blkmov_ctl
module tb_jt900h_blkmov_ctl;

  localparam int K_RD = 0, K_WR = 1, K_UPD = 2, K_DONE = 3;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [15:0] data;
    logic        wsz;
    logic        flag;
    logic        susp;
  } ev_t;

  logic        clk = 0, rst_n = 0, cen = 1, start = 0;
  logic        dec = 0, rep = 0, wsize = 0, irq_pend = 0;
  logic [31:0] src_ptr = 0, dst_ptr = 0;
  logic [15:0] cnt = 0;
  logic        ptr_upd, cnt_dec, busy, done, flag_v, suspended;

  int total = 0, bad = 0;
  int cyc = 0, start_cyc = 0, done_cyc = 0;
  int upd_cnt = 0, done_cnt = 0, ack_dly = 0, wcnt = 0;
  ev_t q[$];

  jt900h_blkmov_if #(.AW(24)) ifc ();

  jt900h_blkmov_ctl #(.AW(24)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .start(start), .dec(dec), .rep(rep),
    .wsize(wsize), .src_ptr(src_ptr), .dst_ptr(dst_ptr), .cnt(cnt), .mem(ifc),
    .ptr_upd(ptr_upd), .cnt_dec(cnt_dec), .busy(busy), .done(done),
    .flag_v(flag_v), .irq_pend(irq_pend), .suspended(suspended)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mdat(input logic [23:0] a);
    return {a[15:8] ^ 8'hA5, a[7:0] ^ 8'h3C};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [31:0] a, input logic [15:0] d,
                      input logic w, input logic f, input logic s);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d; e.wsz = w; e.flag = f; e.susp = s;
    q.push_back(e);
  endtask

  task automatic iter(input logic [31:0] s, input logic [31:0] d, input logic [15:0] data, input logic w);
    push(K_RD, s, 16'h0, w, 1'b0, 1'b0);
    push(K_WR, d, data, w, 1'b0, 1'b0);
    push(K_UPD, 32'h0, 16'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // Memory model: acks after ack_dly enabled cycles of a held request.
  always @(posedge clk) begin
    #3;
    if (!rst_n) begin
      ifc.mem_ack = 1'b0;
      wcnt = 0;
    end else if ((ifc.mem_rd || ifc.mem_wr) && cen) begin
      if (wcnt >= ack_dly) begin
        ifc.mem_ack = 1'b1;
        ifc.mem_din = mdat(ifc.mem_addr);
        wcnt = 0;
      end else begin
        ifc.mem_ack = 1'b0;
        ifc.mem_din = 16'hDEAD;
        wcnt++;
      end
    end else begin
      ifc.mem_ack = 1'b0;
      ifc.mem_din = 16'hDEAD;
    end
  end

  always @(negedge clk) begin
    int  k;
    ev_t e;
    if (rst_n) begin
      k = -1;
      if (ifc.mem_rd && ifc.mem_ack && cen) k = K_RD;
      else if (ifc.mem_wr && ifc.mem_ack && cen) k = K_WR;
      else if (ptr_upd || cnt_dec) k = K_UPD;
      else if (done) k = K_DONE;
      if (k >= 0) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event actual=kind%0d expected=none", k);
        end else begin
          e = q.pop_front();
          check("event_kind", k, e.kind);
          case (k)
            K_RD: begin
              check("rd_addr", ifc.mem_addr, e.addr[23:0]);
              check("rd_wsz", ifc.mem_wsz, e.wsz);
              check("rd_busy", busy, 1);
            end
            K_WR: begin
              check("wr_addr", ifc.mem_addr, e.addr[23:0]);
              check("wr_data", ifc.mem_dout, e.data);
              check("wr_wsz", ifc.mem_wsz, e.wsz);
            end
            K_UPD: begin
              check("upd_strobes", {ptr_upd, cnt_dec}, 2'b11);
              upd_cnt++;
            end
            default: begin
              check("done_flag_v", flag_v, e.flag);
              check("done_suspended", suspended, e.susp);
              done_cyc = cyc;
              done_cnt++;
            end
          endcase
        end
      end
    end
  end

  task automatic go(input logic d, input logic r, input logic w, input logic [31:0] s,
                    input logic [31:0] dd, input logic [15:0] c, input int dly);
    @(posedge clk); #2;
    ack_dly = dly;
    dec = d; rep = r; wsize = w; src_ptr = s; dst_ptr = dd; cnt = c;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input string nm);
    int n = 0;
    while (done_cnt < target && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check(nm, done_cnt >= target, 1);
    check({nm, "_drain"}, q.size(), 0);
  endtask

  task automatic wait_upd(input int target, input string nm);
    int n = 0;
    while (upd_cnt < target && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check(nm, upd_cnt >= target, 1);
  endtask

  initial begin
    ifc.mem_ack = 1'b0;
    ifc.mem_din = 16'hDEAD;
    repeat (3) @(posedge clk);
    #2;
    check("rst_bus", {ifc.mem_rd, ifc.mem_wr, ifc.mem_wsz, ifc.mem_addr}, 0);
    check("rst_dout", ifc.mem_dout, 0);
    check("rst_strobes", {ptr_upd, cnt_dec, busy, done, flag_v, suspended}, 0);
    rst_n = 1'b1;

    // LDI byte, BC=3
    iter(32'h1000, 32'h2000, 16'h003C, 1'b0);
    push(K_DONE, 0, 0, 1'b0, 1'b1, 1'b0);
    go(1'b0, 1'b0, 1'b0, 32'h1000, 32'h2000, 16'd3, 0);
    wait_done(1, "ldi_done");
    check("ldi_latency", done_cyc - start_cyc, 4);

    // LDIR word, BC=2
    iter(32'h100, 32'h200, 16'hA43C, 1'b1);
    iter(32'h102, 32'h202, 16'hA43E, 1'b1);
    push(K_DONE, 0, 0, 1'b0, 1'b0, 1'b0);
    go(1'b0, 1'b1, 1'b1, 32'h100, 32'h200, 16'd2, 0);
    wait_done(2, "ldir_w_done");

    // LDDR byte, BC=1, source wraps below zero
    iter(32'h0, 32'h10, 16'h003C, 1'b0);
    push(K_DONE, 0, 0, 1'b0, 1'b0, 1'b0);
    go(1'b1, 1'b1, 1'b0, 32'h0, 32'h10, 16'd1, 0);
    wait_done(3, "lddr_done");
    check("lddr_src_wrap", dut.src_q, 32'hFFFF_FFFF);
    check("lddr_dst", dut.dst_q, 32'h0000_000F);

    // LDIR byte, BC=0: runs on past zero; stopped after 4 iterations
    iter(32'h300, 32'h400, 16'h003C, 1'b0);
    iter(32'h301, 32'h401, 16'h003D, 1'b0);
    iter(32'h302, 32'h402, 16'h003E, 1'b0);
    iter(32'h303, 32'h403, 16'h003F, 1'b0);
    go(1'b0, 1'b1, 1'b0, 32'h300, 32'h400, 16'd0, 0);
    wait_upd(upd_cnt + 1, "bc0_first_upd");
    check("bc0_flag_after_first", flag_v, 1);
    wait_upd(upd_cnt + 3, "bc0_fourth_upd");
    #1;
    check("bc0_cnt_q", dut.cnt_q, 16'hFFFC);
    check("bc0_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("bc0_drain", q.size(), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Reset during a slow READ, then a normal word iteration with wait states
    go(1'b0, 1'b0, 1'b0, 32'h500, 32'h510, 16'd4, 5);
    @(posedge clk); #2;
    check("abort_rd_before", ifc.mem_rd, 1);
    rst_n = 1'b0;
    #1;
    check("abort_rd_after", ifc.mem_rd, 0);
    check("abort_busy_after", busy, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    iter(32'h600, 32'h700, 16'hA33C, 1'b1);
    push(K_DONE, 0, 0, 1'b0, 1'b1, 1'b0);
    go(1'b0, 1'b0, 1'b1, 32'h600, 32'h700, 16'd7, 2);
    wait_done(done_cnt + 1, "after_abort_done");

    // Clock enable low freezes the pending read
    iter(32'h1234, 32'h4321, 16'h0008, 1'b0);
    push(K_DONE, 0, 0, 1'b0, 1'b1, 1'b0);
    go(1'b0, 1'b0, 1'b0, 32'h1234, 32'h4321, 16'd2, 1);
    cen = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("cen_rd_held", {ifc.mem_rd, busy, ptr_upd}, 3'b110);
    cen = 1'b1;
    wait_done(done_cnt + 1, "cen_done");

`ifdef JT900H_BLKMOV_IRQ_EN
    // LDIR BC=5, interrupt pending from the second iteration on
    iter(32'h800, 32'h900, 16'h003C, 1'b0);
    iter(32'h801, 32'h901, 16'h003D, 1'b0);
    push(K_DONE, 0, 0, 1'b0, 1'b1, 1'b1);
    go(1'b0, 1'b1, 1'b0, 32'h800, 32'h900, 16'd5, 0);
    wait_upd(upd_cnt + 1, "irq_first_upd");
    irq_pend = 1'b1;
    wait_done(done_cnt + 1, "irq_done");
    irq_pend = 1'b0;
`else
    // Without the feature a pending interrupt does not cut LDIR short
    iter(32'h800, 32'h900, 16'h003C, 1'b0);
    iter(32'h801, 32'h901, 16'h003D, 1'b0);
    iter(32'h802, 32'h902, 16'h003E, 1'b0);
    push(K_DONE, 0, 0, 1'b0, 1'b0, 1'b0);
    irq_pend = 1'b1;
    go(1'b0, 1'b1, 1'b0, 32'h800, 32'h900, 16'd3, 0);
    wait_done(done_cnt + 1, "noirq_done");
    irq_pend = 1'b0;
`endif

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jt900h_blkmov_ctl.md
Name: jt900h_blkmov_ctl

Overview:
Sequencer for the TLCS-900H block-transfer instructions LDI, LDIR, LDD and LDDR, in byte and word forms. It moves data from (XHL) to (XDE) through the bus handshake. It drives the register-file step strobes so that XHL, XDE and BC stay architecturally consistent after every iteration. It sits between the instruction decoder, the register file and the memory interface, and owns the bus while busy.

Parameters:
AW, 24, width of emitted memory address (low bits of 32-bit pointers)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cen  in  1  clock enable; all state frozen when low
start  in  1  begin transfer; sampled only in IDLE with cen=1
dec  in  1  0 = increment pointers (LDI/LDIR), 1 = decrement (LDD/LDDR)
rep  in  1  1 = repeat until BC reaches 0
wsize  in  1  0 = byte, 1 = word
src_ptr  in  32  current XHL, latched at start
dst_ptr  in  32  current XDE, latched at start
cnt  in  16  current BC, latched at start
mem_addr  out  AW  bus address
mem_rd  out  1  read request, held until mem_ack
mem_wr  out  1  write request, held until mem_ack
mem_wsz  out  1  copy of latched wsize
mem_ack  in  1  bus completion, one cycle
mem_din  in  16  read data, valid with mem_ack in READ
mem_dout  out  16  write data
ptr_upd  out  1  one-cycle strobe: step XHL and XDE by 1 or 2 (direction = dec_q)
cnt_dec  out  1  one-cycle strobe: BC <= BC-1
busy  out  1  high from the cycle after start acceptance until return to IDLE
done  out  1  one-cycle completion pulse
flag_v  out  1  P/V result: 1 if BC after last decrement != 0
irq_pend  in  1  interrupt pending (used only with the optional feature)

Behaviour:
- Reset values: all outputs 0. State = IDLE. Internal copies are zeroed.
- States: IDLE, READ, WRITE, UPDATE, DONE.
- IDLE: on start&cen, latch src/dst/cnt/dec/rep/wsize, then go to READ. start in any other state is ignored.
- READ:
  - mem_rd=1, mem_addr=src_q[AW-1:0].
  - On mem_ack, capture mem_din into the data register (byte: low 8 bits, upper cleared), then go to WRITE.
  - Requests deassert in the cycle after ack.
- WRITE: mem_wr=1, mem_addr=dst_q, mem_dout=data. On mem_ack, go to UPDATE.
- UPDATE (exactly one cycle):
  - ptr_upd=1 and cnt_dec=1.
  - step = wsize ? 2 : 1. src_q/dst_q ±= step, modulo 2^32 (wrap silently). cnt_q -= 1, modulo 2^16.
  - flag_v <= (cnt_q-1 != 0).
  - Next state: READ if rep and cnt_q-1 != 0, else DONE.
- DONE: done=1 for one cycle, busy drops, then IDLE.
- BC=0 at start: one iteration is always performed. The count wraps to 0xFFFF. With rep, 65536 iterations total. flag_v=1 after the first iteration.
- Non-repeating forms perform exactly one iteration regardless of cnt.
- Minimum iteration latency with zero-wait ack: 3 cycles. Done pulse is 1 cycle after the final UPDATE.
- cen low: no state change, strobes held low, requests held.
- rst_n asserted mid-transfer: immediate return to IDLE, requests dropped. Partial register updates already strobed stand.
- flag_v holds its value until the next UPDATE.

Optional Feature:
JT900H_BLKMOV_IRQ_EN
- Defined:
  - In UPDATE of a repeating transfer with cnt_q-1 != 0 and irq_pend=1, go to DONE instead of READ.
  - Additional output suspended pulses with done. The decoder then leaves PC on the instruction so it restarts after the interrupt.
  - Registers are consistent because ptr_upd/cnt_dec were issued.
- Undefined: irq_pend is ignored; the suspended output is tied 0; LDIR/LDDR are non-interruptible.

Test Plan:
- LDI byte, src=0x1000, dst=0x2000, BC=3, ack next cycle -> one read @0x1000, one write @0x2000, one ptr_upd/cnt_dec, done 4 cycles after start, flag_v=1.
- LDIR word, BC=2, src=0x100, dst=0x200 -> reads at 0x100/0x102, writes at 0x200/0x202, two cnt_dec, flag_v=0, mem_wsz=1 throughout.
- LDDR byte, src=0x0, dst=0x10, BC=1 -> single iteration, src_q wraps to 0xFFFFFFFF, ptr_upd with dec=1, done, flag_v=0.
- LDIR byte, BC=0 -> first UPDATE gives flag_v=1 and the transfer continues; stop the bench after 4 iterations, cnt_q=0xFFFC.
- Mid-READ rst_n low with 5-cycle delayed ack -> mem_rd=0, busy=0 immediately; after release, a new start runs a normal iteration.
- With JT900H_BLKMOV_IRQ_EN, LDIR BC=5, irq_pend=1 during the 2nd UPDATE -> exactly 2 iterations, done and suspended pulse together, flag_v=1.
